// File: rtl/dlx_pkg.sv
// Shared encodings for the DLX multi-cycle control unit: states, opcodes,
// R-type function codes, ALU operation codes and the datapath strobe bundle.
package dlx_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_IF_WAIT = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_WB      = 4'd6,
    ST_BRANCH  = 4'd7,
    ST_JUMP    = 4'd8,
    ST_HALT    = 4'd9,
    ST_ERR     = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // Full 11-bit function field; nonzero upper bits make the encoding illegal.
  localparam logic [10:0] FN_ADD = 11'h020;
  localparam logic [10:0] FN_SUB = 11'h022;
  localparam logic [10:0] FN_AND = 11'h024;
  localparam logic [10:0] FN_OR  = 11'h025;
  localparam logic [10:0] FN_XOR = 11'h026;
  localparam logic [10:0] FN_SLL = 11'h004;
  localparam logic [10:0] FN_SRL = 11'h006;
  localparam logic [10:0] FN_SLT = 11'h02A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_func_t;

  typedef enum logic [2:0] {
    OC_RTYPE, OC_ITYPE, OC_LOAD, OC_STORE, OC_BRANCH, OC_JUMP, OC_HALT, OC_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic ir_load;
    logic ir_oe_s1;
    logic ir_oe_s2;
    logic pc_load;
    logic pc_oe_s1;
    logic mar_load;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
    logic reg_oe_a;
    logic reg_oe_b;
    logic link_sel;
  } strobe_t;

endpackage

// File: rtl/dlx_alu_decode.sv
// Combinational instruction classifier: opcode/function field to instruction
// class, ALU operation and an illegal-encoding flag.
module dlx_alu_decode
  import dlx_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [10:0] func,
  output op_class_t   op_class,
  output alu_func_t   alu_func,
  output logic        illegal
);

  always_comb begin
    op_class = OC_ILLEGAL;
    alu_func = ALU_ADD;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        op_class = OC_RTYPE;
        case (func)
          FN_ADD:  alu_func = ALU_ADD;
          FN_SUB:  alu_func = ALU_SUB;
          FN_AND:  alu_func = ALU_AND;
          FN_OR:   alu_func = ALU_OR;
          FN_XOR:  alu_func = ALU_XOR;
          FN_SLL:  alu_func = ALU_SLL;
          FN_SRL:  alu_func = ALU_SRL;
          FN_SLT:  alu_func = ALU_SLT;
          default: illegal  = 1'b1;
        endcase
      end
      OP_ADDI: op_class = OC_ITYPE;
      OP_ANDI: begin
        op_class = OC_ITYPE;
        alu_func = ALU_AND;
      end
      OP_ORI: begin
        op_class = OC_ITYPE;
        alu_func = ALU_OR;
      end
      // Loads and stores use the adder for base + offset.
      OP_LW:            op_class = OC_LOAD;
      OP_SW:            op_class = OC_STORE;
      OP_BEQZ, OP_BNEZ: op_class = OC_BRANCH;
      OP_J, OP_JAL:     op_class = OC_JUMP;
      OP_HALT:          op_class = OC_HALT;
      default:          illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/dlx_control_fsm.sv
// DLX multi-cycle control FSM with Mealy datapath strobes and sticky status.
// Define DLX_CTRL_TIMEOUT_EN to bound memory waits to MEM_TIMEOUT cycles.
module dlx_control_fsm
  import dlx_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [10:0] opcode_alu,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        ir_load,
  output logic        ir_oe_s1,
  output logic        ir_oe_s2,
  output logic        pc_load,
  output logic        pc_oe_s1,
  output logic        mar_load,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic        reg_oe_a,
  output logic        reg_oe_b,
  output logic        link_sel,
  output logic [3:0]  alu_func,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state
);

  if (MEM_TIMEOUT == 0) begin : g_bad_timeout
    $error("dlx_control_fsm: MEM_TIMEOUT must be at least 1");
  end

  state_t    state_q, state_d;
  strobe_t   stb, stb_o;
  alu_func_t alu_c;
  op_class_t dec_class;
  alu_func_t dec_alu;
  logic      dec_illegal;
  logic      set_illegal;
  logic      halted_q, illegal_q;
  logic      tmo;
  logic      taken;

  dlx_alu_decode u_dec (
    .opcode   (opcode),
    .func     (opcode_alu),
    .op_class (dec_class),
    .alu_func (dec_alu),
    .illegal  (dec_illegal)
  );

  assign taken = ((opcode == OP_BEQZ) &&  alu_zero) ||
                 ((opcode == OP_BNEZ) && !alu_zero);

`ifdef DLX_CTRL_TIMEOUT_EN
  // Counter only ever holds 0..MEM_TIMEOUT-1; reaching MEM_TIMEOUT is the exit.
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  logic [TW-1:0] wait_cnt;
  logic          waiting;
  logic          bus_err_q;

  assign waiting = (state_q == ST_IF_WAIT) || (state_q == ST_MEM_RD) ||
                   (state_q == ST_MEM_WR);
  assign tmo     = waiting && !mem_ready && (wait_cnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (waiting && !mem_ready && !tmo) wait_cnt <= wait_cnt + TW'(1);
      else                               wait_cnt <= '0;
      if (tmo) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALT) halted_q  <= 1'b1;
      if (set_illegal)        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    stb         = '0;
    alu_c       = ALU_ADD;
    set_illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        stb.pc_oe_s1 = 1'b1;
        stb.mar_load = 1'b1;
        state_d      = ST_IF_WAIT;
      end
      ST_IF_WAIT: begin
        stb.mem_rd = 1'b1;
        if (mem_ready) begin
          stb.ir_load = 1'b1;
          state_d     = ST_DECODE;
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          set_illegal = 1'b1;
          state_d     = ST_ERR;
        end else begin
          case (dec_class)
            OC_RTYPE, OC_ITYPE, OC_LOAD, OC_STORE: state_d = ST_EXEC;
            OC_BRANCH: state_d = ST_BRANCH;
            OC_JUMP:   state_d = ST_JUMP;
            OC_HALT:   state_d = ST_HALT;
            default: begin
              set_illegal = 1'b1;
              state_d     = ST_ERR;
            end
          endcase
        end
      end
      ST_EXEC: begin
        stb.reg_oe_a = 1'b1;
        stb.reg_oe_b = (dec_class == OC_RTYPE);
        stb.ir_oe_s2 = (dec_class != OC_RTYPE);
        alu_c        = dec_alu;
        if (dec_class == OC_LOAD)       state_d = ST_MEM_RD;
        else if (dec_class == OC_STORE) state_d = ST_MEM_WR;
        else                            state_d = ST_WB;
      end
      ST_MEM_RD: begin
        stb.mem_rd = 1'b1;
        if (mem_ready) state_d = ST_WB;
        else if (tmo)  state_d = ST_ERR;
      end
      ST_MEM_WR: begin
        stb.mem_wr = 1'b1;
        if (mem_ready) begin
          stb.pc_load = 1'b1;
          state_d     = ST_FETCH;
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        stb.reg_wr  = 1'b1;
        stb.pc_load = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        stb.reg_oe_a = 1'b1;
        stb.pc_load  = 1'b1;
        stb.ir_oe_s1 = taken;
        state_d      = ST_FETCH;
      end
      ST_JUMP: begin
        stb.ir_oe_s1 = 1'b1;
        stb.pc_load  = 1'b1;
        stb.reg_wr   = (opcode == OP_JAL);
        stb.link_sel = (opcode == OP_JAL);
        state_d      = ST_FETCH;
      end
      default: state_d = state_q;  // HALT, ERR and unused codes hold until reset
    endcase
  end

  // Reset gates strobes directly so a mid-access reset drops them at once.
  assign stb_o    = reset ? '0 : stb;
  assign alu_func = reset ? 4'd0 : alu_c;

  assign ir_load  = stb_o.ir_load;
  assign ir_oe_s1 = stb_o.ir_oe_s1;
  assign ir_oe_s2 = stb_o.ir_oe_s2;
  assign pc_load  = stb_o.pc_load;
  assign pc_oe_s1 = stb_o.pc_oe_s1;
  assign mar_load = stb_o.mar_load;
  assign mem_rd   = stb_o.mem_rd;
  assign mem_wr   = stb_o.mem_wr;
  assign reg_wr   = stb_o.reg_wr;
  assign reg_oe_a = stb_o.reg_oe_a;
  assign reg_oe_b = stb_o.reg_oe_b;
  assign link_sel = stb_o.link_sel;

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
